// File: rtl/apb_delay_pkg.sv
// Shared types and fixed-point constants for the APB scaled delayer.
package apb_delay_pkg;

    // Controller states: idle, slave still working, slave done but stretching.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } dly_state_e;

    // Default number of fractional bits in the clock ratio.
    localparam int unsigned DEF_FRAC_W = 32'd10;

    // Fixed-point 1.0 for the default precision.
    localparam int unsigned ONE = 32'd1 << DEF_FRAC_W;

endpackage

// File: rtl/apb_scaled_delayer_if.sv
// APB bus bundle; master drives the request, slave drives the response.
interface apb_scaled_delayer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   paddr;
    logic                psel;
    logic                penable;
    logic [2:0]          pprot;
    logic                pwrite;
    logic [DATA_W-1:0]   pwdata;
    logic [DATA_W/8-1:0] pstrb;
    logic                pready;
    logic [DATA_W-1:0]   prdata;
    logic                pslverr;

    modport master (
        output paddr, psel, penable, pprot, pwrite, pwdata, pstrb,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pprot, pwrite, pwdata, pstrb,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_delay_acc.sv
// Saturating fixed-point accumulate step; splits the result into the
// integer cycle target and the fractional remainder.
module apb_delay_acc #(
    parameter int CNT_W   = 22,
    parameter int FRAC_W  = 10,
    parameter int RATIO_W = 16
) (
    input  logic [CNT_W+FRAC_W-1:0] base_i,
    input  logic [RATIO_W-1:0]      ratio_i,
    output logic [CNT_W+FRAC_W-1:0] acc_o,
    output logic [CNT_W-1:0]        target_o,
    output logic [FRAC_W-1:0]       frac_o,
    output logic                    sat_o
);
    localparam int ACC_W = CNT_W + FRAC_W;

    logic [ACC_W:0] sum_d;

    // Add one ratio step with a carry bit; clamp to all-ones on overflow.
    always_comb begin
        sum_d = {1'b0, base_i} + {{(ACC_W + 1 - RATIO_W){1'b0}}, ratio_i};
        if (sum_d[ACC_W]) begin
            acc_o = {ACC_W{1'b1}};
        end else begin
            acc_o = sum_d[ACC_W-1:0];
        end
    end

    assign target_o = acc_o[ACC_W-1:FRAC_W];
    assign frac_o   = acc_o[FRAC_W-1:0];
    assign sat_o    = &acc_o;

endmodule

// File: rtl/apb_scaled_delayer.sv
// APB timing scaler: stretches each access phase to ratio x slave cycles,
// carrying the fractional remainder so long-run latency is exact.
module apb_scaled_delayer
    import apb_delay_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int FRAC_W       = DEF_FRAC_W,
    parameter int RATIO_W      = 16,
    parameter int CNT_W        = 22,
    parameter int KEEP_RESIDUE = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [RATIO_W-1:0]   ratio,
    input  logic                 bypass,
    apb_scaled_delayer_if.slave  in_apb,
    apb_scaled_delayer_if.master out_apb,
    output logic                 busy
);
    localparam int ACC_W = CNT_W + FRAC_W;

    dly_state_e         state_q;
    logic [ACC_W-1:0]   acc_q;
    logic [FRAC_W-1:0]  residue_q;
    logic [RATIO_W-1:0] ratio_q;
    logic [CNT_W-1:0]   n_q;
    logic [CNT_W-1:0]   remaining_q;
    logic [DATA_W-1:0]  prdata_q;
    logic               pslverr_q;
    logic               byp_q;

    logic               idle_d;
    logic               access_d;
    logic               bypass_d;
    logic [ACC_W-1:0]   base_d;
    logic [RATIO_W-1:0] step_d;
    logic [CNT_W-1:0]   n_d;
    logic [ACC_W-1:0]   acc_d;
    logic [CNT_W-1:0]   target_d;
    logic [FRAC_W-1:0]  frac_d;
    logic               sat_d;
    logic               complete_d;
    logic               direct_d;
    logic               stretch_d;
    logic [FRAC_W-1:0]  residue_d;
    logic [ADDR_W-1:0]  paddr_d;

    assign idle_d     = (state_q == ST_IDLE);
    assign access_d   = in_apb.psel & in_apb.penable & (state_q != ST_HOLD);
    assign complete_d = access_d & out_apb.pready;
    assign direct_d   = complete_d & (bypass_d | (target_d <= n_d));
    assign stretch_d  = complete_d & ~bypass_d & (target_d > n_d);

    // First access cycle starts from the carried residue and the live
    // ratio/bypass; later cycles continue from the values sampled then.
    always_comb begin
        if (idle_d) begin
            base_d   = {{CNT_W{1'b0}}, residue_q};
            step_d   = ratio;
            bypass_d = bypass;
            n_d      = CNT_W'(1);
        end else begin
            base_d   = acc_q;
            step_d   = ratio_q;
            bypass_d = byp_q;
            if (&n_q) begin
                n_d = n_q;
            end else begin
                n_d = n_q + CNT_W'(1);
            end
        end
    end

    // Remainder kept for the next transaction; dropped once the sum clipped.
    always_comb begin
        if ((KEEP_RESIDUE != 0) && !sat_d) begin
            residue_d = frac_d;
        end else begin
            residue_d = {FRAC_W{1'b0}};
        end
    end

    apb_delay_acc #(
        .CNT_W   (CNT_W),
        .FRAC_W  (FRAC_W),
        .RATIO_W (RATIO_W)
    ) u_acc (
        .base_i   (base_d),
        .ratio_i  (step_d),
        .acc_o    (acc_d),
        .target_o (target_d),
        .frac_o   (frac_d),
        .sat_o    (sat_d)
    );

    // Request passes straight through; select/enable are masked while stretching.
    assign paddr_d         = in_apb.paddr;
    assign out_apb.paddr   = paddr_d;
    assign out_apb.pprot   = in_apb.pprot;
    assign out_apb.pwrite  = in_apb.pwrite;
    assign out_apb.pwdata  = in_apb.pwdata;
    assign out_apb.pstrb   = in_apb.pstrb;
    assign out_apb.psel    = in_apb.psel & (state_q != ST_HOLD);
    assign out_apb.penable = in_apb.penable & (state_q != ST_HOLD);

    // Response: live data on a direct completion, latched data otherwise.
    assign in_apb.pready  = direct_d |
                            ((state_q == ST_HOLD) & in_apb.psel & (remaining_q == CNT_W'(1)));
    assign in_apb.prdata  = direct_d ? out_apb.prdata : prdata_q;
    assign in_apb.pslverr = direct_d ? out_apb.pslverr : pslverr_q;
    assign busy           = (state_q != ST_IDLE);

    // Controller state, accumulator, residue and response latches.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            acc_q       <= {ACC_W{1'b0}};
            residue_q   <= {FRAC_W{1'b0}};
            ratio_q     <= {RATIO_W{1'b0}};
            n_q         <= {CNT_W{1'b0}};
            remaining_q <= {CNT_W{1'b0}};
            prdata_q    <= {DATA_W{1'b0}};
            pslverr_q   <= 1'b0;
            byp_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_WAIT: begin
                    if (!in_apb.psel) begin
                        // Master abandoned the transfer (or is simply idle).
                        state_q <= ST_IDLE;
                        acc_q   <= {ACC_W{1'b0}};
                    end else if (access_d) begin
                        if (idle_d) begin
                            ratio_q <= ratio;
                            byp_q   <= bypass;
                        end else begin
                            ratio_q <= ratio_q;
                            byp_q   <= byp_q;
                        end
                        n_q <= n_d;
                        if (bypass_d) begin
                            state_q <= out_apb.pready ? ST_IDLE : ST_WAIT;
                        end else if (direct_d) begin
                            state_q   <= ST_IDLE;
                            acc_q     <= {ACC_W{1'b0}};
                            residue_q <= residue_d;
                        end else if (stretch_d) begin
                            state_q     <= ST_HOLD;
                            acc_q       <= {ACC_W{1'b0}};
                            residue_q   <= residue_d;
                            remaining_q <= target_d - n_d;
                            prdata_q    <= out_apb.prdata;
                            pslverr_q   <= out_apb.pslverr;
                        end else begin
                            state_q <= ST_WAIT;
                            acc_q   <= acc_d;
                        end
                    end else begin
                        state_q <= state_q;
                    end
                end
                ST_HOLD: begin
                    if (!in_apb.psel) begin
                        state_q <= ST_IDLE;
                        acc_q   <= {ACC_W{1'b0}};
                    end else if (remaining_q == CNT_W'(1)) begin
                        state_q <= ST_IDLE;
                    end else begin
                        remaining_q <= remaining_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    acc_q   <= {ACC_W{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_scaled_delayer.sv
// Self-checking bench for apb_scaled_delayer: random APB transfers compared
// against an arithmetic latency/residue model (cycles = max(n, floor(acc))).
module tb_apb_scaled_delayer;
    import apb_delay_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] ratio;
    logic        bypass;
    logic        busy1;
    logic        busy2;

    int errors = 0;
    int checks = 0;
    int unsigned res1_m = 0;
    int unsigned res2_m = 0;

    apb_scaled_delayer_if #(.ADDR_W(32), .DATA_W(32)) in_if  ();
    apb_scaled_delayer_if #(.ADDR_W(32), .DATA_W(32)) out_if ();
    apb_scaled_delayer_if #(.ADDR_W(32), .DATA_W(32)) in2    ();
    apb_scaled_delayer_if #(.ADDR_W(32), .DATA_W(32)) out2   ();

    apb_scaled_delayer dut (
        .clock(clock), .reset(reset), .ratio(ratio), .bypass(bypass),
        .in_apb(in_if), .out_apb(out_if), .busy(busy1)
    );

    apb_scaled_delayer #(.KEEP_RESIDUE(0)) dut_nr (
        .clock(clock), .reset(reset), .ratio(ratio), .bypass(bypass),
        .in_apb(in2), .out_apb(out2), .busy(busy2)
    );

    assign in2.paddr    = in_if.paddr;
    assign in2.psel     = in_if.psel;
    assign in2.penable  = in_if.penable;
    assign in2.pprot    = in_if.pprot;
    assign in2.pwrite   = in_if.pwrite;
    assign in2.pwdata   = in_if.pwdata;
    assign in2.pstrb    = in_if.pstrb;
    assign out2.pready  = out_if.pready;
    assign out2.prdata  = out_if.prdata;
    assign out2.pslverr = out_if.pslverr;

    always #5 clock = ~clock;

    task automatic do_reset();
        @(posedge clock); #1;
        reset = 1'b1;
        in_if.psel = 1'b0; in_if.penable = 1'b0;
        out_if.pready = 1'b0;
        bypass = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b0;
        res1_m = 0;
        res2_m = 0;
    endtask

    // One complete APB transfer; slave becomes ready in access cycle n.
    task automatic run_txn(input logic [15:0] r, input int n, input logic byp,
                           input bit toggle_byp, input bit use2,
                           input logic [31:0] rdata, input logic err, input string tag);
        int unsigned acc_m;
        int unsigned tgt;
        int exp_cyc;
        int got;
        logic rdy;
        if (byp) begin
            exp_cyc = n;
        end else begin
            acc_m = (use2 ? res2_m : res1_m) + int'(r) * n;
            tgt = acc_m / ONE;
            exp_cyc = (int'(tgt) > n) ? int'(tgt) : n;
            if (use2) res2_m = 0;
            else res1_m = acc_m % ONE;
        end
        @(posedge clock); #1;
        in_if.psel = 1'b1; in_if.penable = 1'b0;
        in_if.paddr = $urandom; in_if.pwdata = $urandom;
        in_if.pwrite = 1'($urandom_range(0, 1)); in_if.pprot = 3'($urandom_range(0, 7));
        in_if.pstrb = 4'($urandom_range(0, 15));
        ratio = r; bypass = byp; out_if.pready = 1'b0;
        @(posedge clock); #1;
        in_if.penable = 1'b1;
        got = 0;
        for (int k = 1; k <= 64 && got == 0; k++) begin
            if (k == 2) begin
                ratio = 16'($urandom);
                if (toggle_byp) bypass = ~byp;
            end
            out_if.pready   = (k >= n);
            out_if.prdata   = (k == n) ? rdata : $urandom;
            out_if.pslverr  = (k == n) ? err : ~err;
            @(negedge clock);
            rdy = use2 ? in2.pready : in_if.pready;
            if (!use2) begin
                checks++;
                if (out_if.psel !== ((byp || k <= n) ? 1'b1 : 1'b0)) begin
                    errors++;
                    $display("FAIL %s out_psel k=%0d got=%b exp=%b", tag, k, out_if.psel, (byp || k <= n));
                end
                checks++;
                if (busy1 !== ((k >= 2) ? 1'b1 : 1'b0)) begin
                    errors++;
                    $display("FAIL %s busy k=%0d got=%b", tag, k, busy1);
                end
                if (k == 1) begin
                    checks++;
                    if (out_if.paddr !== in_if.paddr || out_if.pwdata !== in_if.pwdata ||
                        out_if.pstrb !== in_if.pstrb || out_if.pprot !== in_if.pprot ||
                        out_if.pwrite !== in_if.pwrite) begin
                        errors++;
                        $display("FAIL %s request passthrough got=%h exp=%h", tag, out_if.paddr, in_if.paddr);
                    end
                end
            end
            if (rdy === 1'b1) begin
                got = k;
                checks++;
                if ((use2 ? in2.prdata : in_if.prdata) !== rdata ||
                    (use2 ? in2.pslverr : in_if.pslverr) !== err) begin
                    errors++;
                    $display("FAIL %s response got=%h/%b exp=%h/%b", tag,
                             use2 ? in2.prdata : in_if.prdata,
                             use2 ? in2.pslverr : in_if.pslverr, rdata, err);
                end
            end
            @(posedge clock); #1;
        end
        checks++;
        if (got != exp_cyc) begin
            errors++;
            $display("FAIL %s ready_cycle got=%0d exp=%0d (ratio=%0d n=%0d byp=%b)", tag, got, exp_cyc, r, n, byp);
        end
        in_if.psel = 1'b0; in_if.penable = 1'b0;
        out_if.pready = 1'b0; bypass = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clock); #1;
        reset = 1'b1;
        in_if.psel = 1'b0; in_if.penable = 1'b0;
        out_if.pready = 1'b0; out_if.prdata = 32'h1234_5678; out_if.pslverr = 1'b1;
        @(posedge clock);
        @(negedge clock);
        checks++;
        if (in_if.pready !== 1'b0 || busy1 !== 1'b0 || busy2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl pready=%b busy=%b/%b exp=0", in_if.pready, busy1, busy2);
        end
        checks++;
        if (in_if.prdata !== 32'h0 || in_if.pslverr !== 1'b0) begin
            errors++;
            $display("FAIL reset_latch got=%h/%b exp=0/0", in_if.prdata, in_if.pslverr);
        end
        checks++;
        if (out_if.psel !== 1'b0 || out_if.penable !== 1'b0) begin
            errors++;
            $display("FAIL reset_outsel got=%b/%b exp=0/0", out_if.psel, out_if.penable);
        end
        #1;
        @(posedge clock); #1;
        reset = 1'b0;
        res1_m = 0; res2_m = 0;
    endtask

    task automatic test_ratio_carry();
        do_reset();
        run_txn(16'd5831, 1, 1'b0, 1'b0, 1'b0, $urandom, 1'b0, "carry1");
        run_txn(16'd5831, 1, 1'b0, 1'b0, 1'b0, $urandom, 1'b1, "carry2");
    endtask

    task automatic test_hold_latch();
        do_reset();
        run_txn(16'd2048, 3, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b1, "hold_latch");
    endtask

    task automatic test_direct();
        do_reset();
        run_txn(16'd512, 2, 1'b0, 1'b0, 1'b0, $urandom, 1'b0, "direct");
        run_txn(16'd0, 3, 1'b0, 1'b0, 1'b0, $urandom, 1'b1, "ratio_zero");
        run_txn(16'd5831, 1, 1'b0, 1'b0, 1'b0, $urandom, 1'b0, "after_direct");
    endtask

    task automatic test_bypass();
        do_reset();
        run_txn(16'd5831, 1, 1'b0, 1'b0, 1'b0, $urandom, 1'b0, "pre_bypass");
        run_txn(16'd5831, 3, 1'b1, 1'b1, 1'b0, $urandom, 1'b1, "bypass_toggle");
        run_txn(16'd5831, 1, 1'b1, 1'b0, 1'b0, $urandom, 1'b0, "bypass_n1");
        run_txn(16'd5831, 1, 1'b0, 1'b0, 1'b0, $urandom, 1'b0, "post_bypass");
        run_txn(16'd2048, 2, 1'b0, 1'b1, 1'b0, $urandom, 1'b1, "late_bypass");
    endtask

    task automatic test_reset_hold();
        do_reset();
        run_txn(16'd5831, 1, 1'b0, 1'b0, 1'b0, $urandom, 1'b0, "warmup");
        @(posedge clock); #1;
        in_if.psel = 1'b1; in_if.penable = 1'b0; ratio = 16'd5831;
        @(posedge clock); #1;
        in_if.penable = 1'b1; out_if.pready = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (busy1 !== 1'b1) begin
            errors++;
            $display("FAIL rst_hold pre busy got=%b exp=1", busy1);
        end
        @(negedge clock);
        checks++;
        if (in_if.pready !== 1'b0 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL rst_hold post pready=%b busy=%b exp=0/0", in_if.pready, busy1);
        end
        @(posedge clock); #1;
        reset = 1'b0; in_if.psel = 1'b0; in_if.penable = 1'b0; out_if.pready = 1'b0;
        res1_m = 0; res2_m = 0;
        run_txn(16'd5831, 1, 1'b0, 1'b0, 1'b0, $urandom, 1'b1, "after_rst_hold");
    endtask

    task automatic test_psel_drop();
        do_reset();
        @(posedge clock); #1;
        in_if.psel = 1'b1; in_if.penable = 1'b0; ratio = 16'd5831;
        @(posedge clock); #1;
        in_if.penable = 1'b1; out_if.pready = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        in_if.psel = 1'b0; in_if.penable = 1'b0;
        @(negedge clock);
        checks++;
        if (in_if.pready !== 1'b0) begin
            errors++;
            $display("FAIL psel_drop pready got=%b exp=0", in_if.pready);
        end
        @(negedge clock);
        checks++;
        if (busy1 !== 1'b0) begin
            errors++;
            $display("FAIL psel_drop busy got=%b exp=0", busy1);
        end
        #1;
        out_if.pready = 1'b0;
        res1_m = 5831 % ONE;
        run_txn(16'd5831, 1, 1'b0, 1'b0, 1'b0, $urandom, 1'b0, "after_drop");
    endtask

    task automatic test_no_residue();
        do_reset();
        run_txn(16'd5831, 1, 1'b0, 1'b0, 1'b1, $urandom, 1'b0, "nores1");
        run_txn(16'd5831, 1, 1'b0, 1'b0, 1'b1, $urandom, 1'b1, "nores2");
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 24; i++) begin
            run_txn(16'($urandom_range(0, 6000)), $urandom_range(1, 4),
                    ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 1'b0,
                    $urandom, 1'($urandom_range(0, 1)), "random");
        end
    endtask

    initial begin
        reset = 1'b1; ratio = 16'd0; bypass = 1'b0;
        in_if.paddr = 32'h0; in_if.psel = 1'b0; in_if.penable = 1'b0;
        in_if.pprot = 3'd0; in_if.pwrite = 1'b0; in_if.pwdata = 32'h0; in_if.pstrb = 4'h0;
        out_if.pready = 1'b0; out_if.prdata = 32'h0; out_if.pslverr = 1'b0;
        test_reset();
        test_ratio_carry();
        test_hold_latch();
        test_direct();
        test_bypass();
        test_reset_hold();
        test_psel_drop();
        test_no_residue();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
